// File: rtl/restoring_divider_hs_if.sv
// Handshake bundle for restoring_divider_hs: operand channel in, result channel out.
interface restoring_divider_hs_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dd_in;
  logic [N-1:0] dr_in;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         ovf;

  modport master (
    output in_valid, dd_in, dr_in, signed_mode, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dd_in, dr_in, signed_mode, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/restoring_divider_hs.sv
// Multi-cycle restoring divider, signed or unsigned per operation, with valid/ready
// handshakes and explicit divide-by-zero / signed-overflow reporting.
module restoring_divider_hs #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  restoring_divider_hs_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int           CW      = $clog2(N + 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   prem;      // partial remainder, always below the divisor magnitude
  logic [N-1:0]   dd_sh;     // dividend magnitude, consumed MSB first
  logic [N-1:0]   dr_mag;
  logic [N-1:0]   quo;
  logic [N-1:0]   dd_raw;
  logic           q_neg, r_neg, dz_r, ovf_r;

  logic [N-1:0]   q_o, r_o;
  logic           dz_o, ovf_o;

  logic           dd_neg, dr_neg;
  logic [N-1:0]   dd_abs, dr_abs;
  logic [N:0]     shifted, trial;
  logic [N-1:0]   q_fix, r_fix;

  assign dd_neg  = bus.signed_mode & bus.dd_in[N-1];
  assign dr_neg  = bus.signed_mode & bus.dr_in[N-1];
  assign dd_abs  = dd_neg ? -bus.dd_in : bus.dd_in;
  assign dr_abs  = dr_neg ? -bus.dr_in : bus.dr_in;

  assign shifted = {prem, dd_sh[N-1]};
  assign trial   = shifted - {1'b0, dr_mag};
  assign q_fix   = q_neg ? -quo  : quo;
  assign r_fix   = r_neg ? -prem : prem;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid)       state_nx = CALC;
      CALC:    if (cnt == CW'(1))      state_nx = FIX;
      FIX:                             state_nx = DONE;
      DONE:    if (bus.out_ready)      state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      prem   <= '0;
      dd_sh  <= '0;
      dr_mag <= '0;
      quo    <= '0;
      dd_raw <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
      q_o    <= '0;
      r_o    <= '0;
      dz_o   <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          cnt    <= CW'(N);
          prem   <= '0;
          quo    <= '0;
          dd_sh  <= dd_abs;
          dr_mag <= dr_abs;
          dd_raw <= bus.dd_in;
          q_neg  <= dd_neg ^ dr_neg;
          r_neg  <= dd_neg;
          dz_r   <= (bus.dr_in == '0);
          ovf_r  <= bus.signed_mode && (bus.dd_in == MIN_NEG) && (bus.dr_in == '1);
        end
        CALC: begin
          // A set trial MSB means the subtraction went negative: keep the old value.
          prem  <= trial[N] ? shifted[N-1:0] : trial[N-1:0];
          quo   <= {quo[N-2:0], ~trial[N]};
          dd_sh <= {dd_sh[N-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (dz_r) begin
            q_o   <= '1;
            r_o   <= dd_raw;
            dz_o  <= 1'b1;
            ovf_o <= 1'b0;
          end else if (ovf_r) begin
            q_o   <= MIN_NEG;
            r_o   <= '0;
            dz_o  <= 1'b0;
            ovf_o <= 1'b1;
          end else begin
            q_o   <= q_fix;
            r_o   <= r_fix;
            dz_o  <= 1'b0;
            ovf_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = q_o;
  assign bus.remainder = r_o;
  assign bus.div_zero  = dz_o;
  assign bus.ovf       = ovf_o;

endmodule

// File: tb/tb_restoring_divider_hs.sv
// Scoreboard bench for restoring_divider_hs: expectations are queued at acceptance
// and compared when the result handshake completes.
module tb_restoring_divider_hs;

  localparam int N       = 8;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  restoring_divider_hs_if #(.N(N)) bus ();

  restoring_divider_hs #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from integer arithmetic (SV / and % truncate toward zero).
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    exp_t e;
    int   sa, sb_i;
    e = '0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (sm && a == 8'h80 && b == 8'hFF) begin
      e.q   = 8'h80;
      e.r   = '0;
      e.ovf = 1'b1;
    end else if (sm) begin
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
      e.q  = N'(sa / sb_i);
      e.r  = N'(sa % sb_i);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Present operands, wait for acceptance, and push the expectation.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    int waited = 0;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.dd_in       = a;
    bus.dr_in       = b;
    bus.signed_mode = sm;
    while (!bus.in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_timeout", 32'(waited < TIMEOUT), 32'd1);
    @(posedge clk);
    sb.push_back(model(a, b, sm));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dd_in    = $urandom_range(0, 255);
    bus.dr_in    = $urandom_range(0, 255);
  endtask

  // Count edges from acceptance to out_valid, then compare against the queue head.
  task automatic collect(input string tag, input int hold);
    int   lat = 0;
    exp_t e;
    while (!bus.out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N + 1));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      check({tag, "_q"},   32'(bus.quotient),  32'(e.q));
      check({tag, "_r"},   32'(bus.remainder), 32'(e.r));
      check({tag, "_dz"},  32'(bus.div_zero),  32'(e.dz));
      check({tag, "_ovf"}, 32'(bus.ovf),       32'(e.ovf));
      if (hold > 0) begin
        check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
        bus.in_valid = (i % 2 == 0);
        bus.dd_in    = 8'd99;
        bus.dr_in    = 8'd3;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sm);
    issue(a, b, sm);
    collect(tag, 0);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.dd_in       = '0;
    bus.dr_in       = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_q",         32'(bus.quotient),  32'd0);
    check("rst_r",         32'(bus.remainder), 32'd0);
    check("rst_flags",     32'({bus.div_zero, bus.ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("s_100_7",   8'd100,          8'd7,    1'b1);
    run_div("s_m100_7",  8'(-100),        8'd7,    1'b1);
    run_div("s_100_m7",  8'd100,          8'(-7),  1'b1);
    run_div("s_m100_m7", 8'(-100),        8'(-7),  1'b1);
    run_div("s_ovf",     8'h80,           8'hFF,   1'b1);
    run_div("u_200_7",   8'd200,          8'd7,    1'b0);
    run_div("u_255_1",   8'd255,          8'd1,    1'b0);
    run_div("s_37_0",    8'd37,           8'd0,    1'b1);
    run_div("u_37_0",    8'd37,           8'd0,    1'b0);
    run_div("s_m5_0",    8'(-5),          8'd0,    1'b1);
    run_div("u_128_255", 8'h80,           8'hFF,   1'b0);
    run_div("s_m128_1",  8'h80,           8'd1,    1'b1);

    for (int i = 0; i < 8; i++)
      run_div("rand", N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));

    // Back-pressure: result held five cycles, stray in_valid pulses ignored.
    issue(8'd77, 8'd5, 1'b0);
    collect("hold", 5);
    run_div("b2b", 8'(-77), 8'd5, 1'b1);

    // Reset mid-CALC abandons the division.
    issue(8'd50, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) begin
      @(negedge clk);
      check("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end
    run_div("after_rst", 8'd123, 8'd10, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
